// File: rtl/zoom_hdmi_pkg.sv
// Shared types and default 720p timing for the zoom-to-HDMI pixel output path.
package zoom_hdmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_H_ACTIVE   = 1280;
    localparam int DEF_H_FP       = 110;
    localparam int DEF_H_SYNC     = 40;
    localparam int DEF_H_BP       = 220;
    localparam int DEF_V_ACTIVE   = 720;
    localparam int DEF_V_FP       = 5;
    localparam int DEF_V_SYNC     = 5;
    localparam int DEF_V_BP       = 20;

    // Total period of one axis: active region plus both porches and sync.
    function automatic int timingTotal(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/zoom_hdmi_timing_cnt.sv
// Horizontal/vertical raster counters and the combinational timing decode.
// Raster order on both axes is active, front porch, sync, back porch.
module zoom_hdmi_timing_cnt
    import zoom_hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic load_i,
    output logic act_o,
    output logic hsRaw_o,
    output logic vsRaw_o,
    output logic frameEnd_o,
    output logic bpStart_o
);

    localparam int H_TOTAL = timingTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timingTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    logic [HW-1:0] hCnt_q, hCnt_d;
    logic [VW-1:0] vCnt_q, vCnt_d;

    // Next counter values: a start loads the top of vertical blank, idle parks at zero.
    always_comb begin
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (load_i) begin
            hCnt_d = '0;
            vCnt_d = V_ACT_C;
        end else if (!run_i) begin
            hCnt_d = '0;
            vCnt_d = '0;
        end else if (hCnt_q == H_LAST_C) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == V_LAST_C) ? '0 : vCnt_q + 1'b1;
        end else begin
            hCnt_d = hCnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    assign act_o      = (hCnt_q < H_ACT_C) && (vCnt_q < V_ACT_C);
    assign hsRaw_o    = (hCnt_q >= H_SS_C) && (hCnt_q < H_SE_C);
    assign vsRaw_o    = (vCnt_q >= V_SS_C) && (vCnt_q < V_SE_C);
    assign frameEnd_o = (hCnt_q == H_LAST_C) && (vCnt_q == V_LAST_C);
    assign bpStart_o  = (hCnt_q == '0) && (vCnt_q == V_SE_C);

endmodule

// File: rtl/zoom_hdmi_pixel_out.sv
// HDMI pixel sink: generates video timing, pops the show-ahead prefetch FIFO once
// per active pixel, and blanks the rest of a frame after an underflow.
module zoom_hdmi_pixel_out
    import zoom_hdmi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int HS_POL     = 1,
    parameter int VS_POL     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_vld,
    output logic                  fifo_rd_en,
    output logic                  frame_start,
    output logic                  underflow,
    output logic                  underflow_sticky,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  vid_hs,
    output logic                  vid_vs,
    output logic                  vid_de
);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    state_e state_q, state_d;

    logic act, hsRaw, vsRaw, frameEnd, bpStart;
    logic running, startRun, underflowEvt;

    logic [DATA_WIDTH-1:0] vidData_q;
    logic                  vidHs_q, vidVs_q, vidDe_q;
    logic                  underflow_q, sticky_q;

    assign running      = (state_q != ST_IDLE);
    assign startRun     = (state_q == ST_IDLE) && en;
    assign underflowEvt = (state_q == ST_RUN) && act && !fifo_rd_vld;

    zoom_hdmi_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) uTiming (
        .clk        (clk),
        .rst        (rst),
        .run_i      (running),
        .load_i     (startRun),
        .act_o      (act),
        .hsRaw_o    (hsRaw),
        .vsRaw_o    (vsRaw),
        .frameEnd_o (frameEnd),
        .bpStart_o  (bpStart)
    );

    // Next state: underflow drops to RESYNC until frame end; en only matters at frame boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (underflowEvt)         state_d = ST_RESYNC;
                else if (frameEnd && !en) state_d = ST_IDLE;
            end
            ST_RESYNC: begin
                if (frameEnd) state_d = en ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pop request: one per active pixel while running, continuous drain while resyncing.
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state_q)
            ST_RUN:    fifo_rd_en = act;
            ST_RESYNC: fifo_rd_en = fifo_rd_vld;
            default:   fifo_rd_en = 1'b0;
        endcase
    end

    // State, registered video outputs and underflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vidData_q   <= '0;
            vidDe_q     <= 1'b0;
            vidHs_q     <= ~HS_ON;
            vidVs_q     <= ~VS_ON;
            underflow_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vidDe_q     <= running && act;
            vidData_q   <= ((state_q == ST_RUN) && act && fifo_rd_vld) ? fifo_rd_data : '0;
            vidHs_q     <= running ? ~(hsRaw ^ HS_ON) : ~HS_ON;
            vidVs_q     <= running ? ~(vsRaw ^ VS_ON) : ~VS_ON;
            underflow_q <= underflowEvt;
            sticky_q    <= sticky_q || underflowEvt;
        end
    end

    assign frame_start      = running && bpStart;
    assign underflow        = underflow_q;
    assign underflow_sticky = sticky_q;
    assign vid_data         = vidData_q;
    assign vid_hs           = vidHs_q;
    assign vid_vs           = vidVs_q;
    assign vid_de           = vidDe_q;

endmodule

// File: tb/tb_zoom_hdmi_pixel_out.sv
// Directed bench for zoom_hdmi_pixel_out using a tiny 14x8 raster.
// Sample index k counts clocks from entry into RUN (k=0 has h=0, v=4).
module tb_zoom_hdmi_pixel_out;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_vld = 1'b0;
    logic          fifo_rd_en, frame_start, underflow, underflow_sticky;
    logic [DW-1:0] vid_data;
    logic          vid_hs, vid_vs, vid_de;

    int popCount   = 0;
    int wordOffset = 0;

    int total = 0;
    int bad   = 0;

    int k;
    int deCnt, hsCnt, vsCnt, fsCnt, ufCnt, rdEnHigh;
    int firstFs, secondFs, firstDe;
    int dataErr, rdEnErr, blackErr, expPix, popStart;
    bit chkData, chkRdEn, chkBlack;

    always #5 clk = ~clk;

    // Show-ahead FIFO stand-in: head word is the running pop count plus one.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_rd_vld) popCount <= popCount + 1;
    end

    assign fifo_rd_data = 24'(wordOffset + popCount + 1);

    zoom_hdmi_pixel_out #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (2),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (1),
        .V_BP       (2),
        .HS_POL     (1),
        .VS_POL     (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_vld      (fifo_rd_vld),
        .fifo_rd_en       (fifo_rd_en),
        .frame_start      (frame_start),
        .underflow        (underflow),
        .underflow_sticky (underflow_sticky),
        .vid_data         (vid_data),
        .vid_hs           (vid_hs),
        .vid_vs           (vid_vs),
        .vid_de           (vid_de)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic bit expAct(input int kk);
        int h, v;
        h = kk % 14;
        v = (4 + kk / 14) % 8;
        return (h < 8) && (v < 4);
    endfunction

    task automatic clearStats();
        deCnt = 0; hsCnt = 0; vsCnt = 0; fsCnt = 0; ufCnt = 0; rdEnHigh = 0;
        firstFs = -1; secondFs = -1; firstDe = -1;
        dataErr = 0; rdEnErr = 0; blackErr = 0;
        popStart = popCount;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        k++;
        if (vid_de) begin
            deCnt++;
            if (firstDe < 0) firstDe = k;
            if (chkData) begin
                if (vid_data !== 24'(expPix)) dataErr++;
                expPix++;
            end
            if (chkBlack && vid_data !== '0) blackErr++;
        end
        if (vid_hs) hsCnt++;
        if (vid_vs) vsCnt++;
        if (underflow) ufCnt++;
        if (fifo_rd_en) rdEnHigh++;
        if (frame_start) begin
            fsCnt++;
            if (firstFs < 0) firstFs = k;
            else if (secondFs < 0) secondFs = k;
        end
        if (chkRdEn && fifo_rd_en !== expAct(k)) rdEnErr++;
    endtask

    initial begin
        chkData = 0; chkRdEn = 0; chkBlack = 0; expPix = 1; k = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstDe", vid_de, 0);
        checkOutput("rstData", vid_data, 0);
        checkOutput("rstHs", vid_hs, 0);
        checkOutput("rstVs", vid_vs, 0);
        checkOutput("rstRdEn", fifo_rd_en, 0);
        checkOutput("rstFs", frame_start, 0);
        checkOutput("rstSticky", underflow_sticky, 0);

        // Frame 1: timing and data order, FIFO always valid
        rst = 0; en = 1; fifo_rd_vld = 1;
        clearStats(); chkData = 1; chkRdEn = 1; expPix = 1; k = -1;
        for (int i = 0; i < 168; i++) begin
            applyStimulus();
            case (k)
                10: checkOutput("hsBefore", vid_hs, 0);
                11: checkOutput("hsFirst", vid_hs, 1);
                12: checkOutput("hsSecond", vid_hs, 1);
                13: checkOutput("hsAfter", vid_hs, 0);
                14: checkOutput("vsBefore", vid_vs, 0);
                15: checkOutput("vsFirst", vid_vs, 1);
                28: checkOutput("vsLast", vid_vs, 1);
                29: checkOutput("vsAfter", vid_vs, 0);
                default: ;
            endcase
        end
        checkOutput("firstFs", firstFs, 28);
        checkOutput("secondFs", secondFs, 140);
        checkOutput("fsCountA", fsCnt, 2);
        checkOutput("firstDe", firstDe, 57);
        checkOutput("deCountA", deCnt, 32);
        checkOutput("hsCountA", hsCnt, 24);
        checkOutput("vsCountA", vsCnt, 28);
        checkOutput("dataOrderA", dataErr, 0);
        checkOutput("popsA", popCount - popStart, 32);
        checkOutput("rdEnOnlyActA", rdEnErr, 0);

        // Frame 2: underflow at pixel 3 of line 1
        clearStats(); chkData = 0; chkRdEn = 0;
        for (int i = 0; i < 112; i++) begin
            applyStimulus();
            case (k)
                183: checkOutput("pix41", vid_data, 41);
                184: checkOutput("pix42", vid_data, 42);
                185: begin
                    checkOutput("pix43", vid_data, 43);
                    fifo_rd_vld = 0;
                end
                186: begin
                    checkOutput("ufPulse", underflow, 1);
                    checkOutput("ufSticky", underflow_sticky, 1);
                    checkOutput("ufPixDe", vid_de, 1);
                    checkOutput("ufPixData", vid_data, 0);
                    chkBlack = 1;
                end
                187: checkOutput("drainIdle", fifo_rd_en, 0);
                190: fifo_rd_vld = 1;
                200: checkOutput("drainAct", fifo_rd_en, 1);
                240: checkOutput("drainBlank", fifo_rd_en, 1);
                278: fifo_rd_vld = 0;
                279: begin
                    checkOutput("drainStop", fifo_rd_en, 0);
                    checkOutput("stickyHeld", underflow_sticky, 1);
                end
                default: ;
            endcase
        end
        chkBlack = 0;
        checkOutput("ufCountB", ufCnt, 1);
        checkOutput("deCountB", deCnt, 32);
        checkOutput("blackB", blackErr, 0);
        checkOutput("fsCountB", fsCnt, 1);

        // Frame 3: normal data again; en dropped mid-frame
        clearStats(); chkData = 1; chkRdEn = 1; expPix = 1;
        for (int i = 0; i < 112; i++) begin
            applyStimulus();
            if (k == 280) begin
                wordOffset = -popCount;
                fifo_rd_vld = 1;
                popStart = popCount;
            end
            if (k == 300) en = 0;
        end
        checkOutput("dataOrderC", dataErr, 0);
        checkOutput("deCountC", deCnt, 32);
        checkOutput("ufCountC", ufCnt, 0);
        checkOutput("popsC", popCount - popStart, 32);
        checkOutput("rdEnOnlyActC", rdEnErr, 0);
        checkOutput("fsCountC", fsCnt, 1);

        // Idle after the frame completes
        clearStats(); chkData = 0; chkRdEn = 0;
        repeat (30) applyStimulus();
        checkOutput("idleDe", deCnt, 0);
        checkOutput("idlePops", popCount - popStart, 0);
        checkOutput("idleRdEn", rdEnHigh, 0);
        checkOutput("idleFs", fsCnt, 0);
        checkOutput("idleHs", vid_hs, 0);

        // Restart from the top of vertical blank
        en = 1;
        clearStats(); k = -1;
        repeat (60) applyStimulus();
        checkOutput("restartFs", firstFs, 28);
        checkOutput("restartDe", firstDe, 57);
        checkOutput("preRstSticky", underflow_sticky, 1);
        checkOutput("preRstRdEn", fifo_rd_en, 1);

        // Reset mid-line
        rst = 1; en = 0;
        applyStimulus();
        checkOutput("midRstDe", vid_de, 0);
        checkOutput("midRstData", vid_data, 0);
        checkOutput("midRstHs", vid_hs, 0);
        checkOutput("midRstVs", vid_vs, 0);
        checkOutput("midRstRdEn", fifo_rd_en, 0);
        checkOutput("midRstFs", frame_start, 0);
        checkOutput("midRstUf", underflow, 0);
        checkOutput("midRstSticky", underflow_sticky, 0);
        rst = 0;
        clearStats();
        repeat (20) applyStimulus();
        checkOutput("postRstDe", deCnt, 0);
        checkOutput("postRstRdEn", rdEnHigh, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
